// File: rtl/imem_loader.sv
// imem_loader: turns a length-prefixed byte stream into little-endian 32-bit
// instruction-memory writes at consecutive word addresses. The core is held in
// reset (cpu_rst low) until the whole image has been written.
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,       // asynchronous, active low
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cpu_rst
);

  // Word counter must hold any 16-bit length and also supply ADDR_WIDTH address bits.
  localparam int CW = (ADDR_WIDTH > 16) ? ADDR_WIDTH : 16;
  // Largest image that fits between BASE_ADDR and the top of memory.
  localparam logic [32:0] MAX_WORDS = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);

  // S_FLUSH is the cycle carrying the final write strobe, so DONE follows it.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           len_q, len_d;
  logic [CW-1:0]         word_cnt_q, word_cnt_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           asm_q, asm_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;

  logic                  accept;
  logic [15:0]           n_hdr;
  logic [CW-1:0]         word_cnt_inc;

  assign accept       = in_valid && in_ready;
  assign n_hdr        = {in_data, len_lo_q};
  assign word_cnt_inc = word_cnt_q + CW'(1);

  // Status outputs decode straight from the state register.
  assign in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
  assign busy     = in_ready || (state_q == S_FLUSH);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign cpu_rst  = done;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

  // Next-state, header capture, byte assembly and write-strobe generation.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_LO;
          len_lo_d   = '0;
          len_d      = '0;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          asm_d      = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = in_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = n_hdr;
          if ((n_hdr == 16'd0) || (33'(n_hdr) > MAX_WORDS)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          unique case (byte_cnt_q)
            2'd0: asm_d[7:0]   = in_data;
            2'd1: asm_d[15:8]  = in_data;
            2'd2: asm_d[23:16] = in_data;
            default: begin
              wr_en_d    = 1'b1;
              wr_data_d  = {in_data, asm_q};
              wr_addr_d  = ADDR_WIDTH'(BASE_ADDR) + word_cnt_q[ADDR_WIDTH-1:0];
              word_cnt_d = word_cnt_inc;
              if (word_cnt_inc == CW'(len_q)) begin
                state_d = S_FLUSH;
              end
            end
          endcase
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, basic load, gapped stream, header
// errors, abort by reset, and a full-depth image checked write by write.
module tb_imem_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          done;
  logic          err;
  logic          cpu_rst;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];

  logic [7:0] t2_img [0:9] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                               8'h93, 8'h05, 8'h20, 8'h00};

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_rst  (cpu_rst)
  );

  always #5 clk = ~clk;

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b1 && wr_en === 1'b1) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_t2(input int max_gap);
    for (int i = 0; i < 10; i++) begin
      if (max_gap > 0) begin
        int g = $urandom_range(0, max_gap);
        repeat (g) tick();
      end
      send_byte(t2_img[i]);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("wait_done", 32'(done), 32'd1);
  endtask

  task automatic clear_writes();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic check_t2_writes(input string tag);
    check({tag, "_nwr"}, 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      check({tag, "_a0"}, 32'(wa_q[0]), 32'd0);
      check({tag, "_d0"}, wd_q[0], 32'h0010_0513);
      check({tag, "_a1"}, 32'(wa_q[1]), 32'd1);
      check({tag, "_d1"}, wd_q[1], 32'h0020_0593);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_wr_en"},    32'(wr_en),    32'd0);
    check({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
    check({tag, "_wr_data"},  wr_data,       32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
    check({tag, "_cpu_rst"},  32'(cpu_rst),  32'd0);
  endtask

  initial begin
    // T1: reset held with a byte offered.
    rst = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) tick();
    check_all_zero("t1");
    check("t1_nwr", 32'(wa_q.size()), 32'd0);
    rst = 1'b1;
    tick();
    check("t1_idle_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    tick();

    // T2: basic two-word image, exact write and done timing.
    clear_writes();
    pulse_start();
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_ready", 32'(in_ready), 32'd1);
    send_t2(0);
    check("t2_last_wr_en", 32'(wr_en), 32'd1);
    check("t2_last_addr", 32'(wr_addr), 32'd1);
    check("t2_last_data", wr_data, 32'h0020_0593);
    check("t2_not_done_yet", 32'(done), 32'd0);
    check("t2_cpu_rst_low", 32'(cpu_rst), 32'd0);
    tick();
    check("t2_done", 32'(done), 32'd1);
    check("t2_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t2_busy_off", 32'(busy), 32'd0);
    check("t2_wr_en_off", 32'(wr_en), 32'd0);
    check("t2_ready_off", 32'(in_ready), 32'd0);
    check("t2_addr_hold", 32'(wr_addr), 32'd1);
    check("t2_data_hold", wr_data, 32'h0020_0593);
    check_t2_writes("t2");

    // T3: same image with random gaps; start from DONE clears done.
    clear_writes();
    pulse_start();
    check("t3_done_clr", 32'(done), 32'd0);
    check("t3_cpu_rst_clr", 32'(cpu_rst), 32'd0);
    send_t2(5);
    wait_done();
    check_t2_writes("t3");

    // T4: zero length, then oversize length, then a good image.
    clear_writes();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    check("t4_zero_err", 32'(err), 32'd1);
    check("t4_zero_ready", 32'(in_ready), 32'd0);
    check("t4_zero_cpu_rst", 32'(cpu_rst), 32'd0);
    check("t4_zero_busy", 32'(busy), 32'd0);
    in_valid = 1'b1; in_data = 8'h55;
    repeat (6) tick();
    in_valid = 1'b0;
    check("t4_zero_nwr", 32'(wa_q.size()), 32'd0);
    check("t4_zero_err_sticky", 32'(err), 32'd1);
    pulse_start();
    check("t4_err_clr", 32'(err), 32'd0);
    send_byte(8'h01);
    send_byte(8'h04);
    check("t4_big_err", 32'(err), 32'd1);
    check("t4_big_cpu_rst", 32'(cpu_rst), 32'd0);
    repeat (3) tick();
    check("t4_big_nwr", 32'(wa_q.size()), 32'd0);
    pulse_start();
    send_t2(0);
    wait_done();
    check("t4_recover_err", 32'(err), 32'd0);
    check_t2_writes("t4");

    // T5: start ignored mid-DATA, then reset mid-word, then reload.
    clear_writes();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    pulse_start();
    check("t5_start_ign_busy", 32'(busy), 32'd1);
    check("t5_start_ign_ready", 32'(in_ready), 32'd1);
    send_byte(8'h05);
    rst = 1'b0;
    #1;
    check_all_zero("t5_rst");
    tick();
    rst = 1'b1;
    tick();
    check("t5_abort_nwr", 32'(wa_q.size()), 32'd0);
    pulse_start();
    send_t2(0);
    wait_done();
    check_t2_writes("t5");

    // T6: full-depth image, word i carries value i.
    clear_writes();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h04);
    check("t6_hdr_ok_err", 32'(err), 32'd0);
    for (int i = 0; i < 1024; i++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(8'((i >> (8 * k)) & 8'hFF));
      end
    end
    check("t6_last_wr_en", 32'(wr_en), 32'd1);
    check("t6_last_addr", 32'(wr_addr), 32'h3FF);
    check("t6_last_data", wr_data, 32'h0000_03FF);
    wait_done();
    check("t6_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t6_nwr", 32'(wa_q.size()), 32'd1024);
    if (wa_q.size() == 1024) begin
      for (int i = 0; i < 1024; i++) begin
        check($sformatf("t6_a%0d", i), 32'(wa_q[i]), 32'(i));
        check($sformatf("t6_d%0d", i), wd_q[i], 32'(i));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
